// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler: collects resolved branches from NREQ
// branch units into a circular queue and feeds them one per cycle to the
// predictor update port.
module bp_update_scheduler #(
  parameter int NREQ  = 3,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][XLEN-1:0] req_pc,
  input  logic [NREQ-1:0]           req_direction,
  input  logic [NREQ-1:0][XLEN-1:0] req_target,
  output logic [NREQ-1:0]           req_ready,
  output logic                      upd_valid,
  output logic [XLEN-1:0]           upd_pc,
  output logic                      upd_direction,
  output logic [XLEN-1:0]           upd_target,
  input  logic                      upd_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            dir;
    logic [XLEN-1:0] tgt;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   free;
  logic [31:0]   nvld;
  logic [31:0]   nacc;
  logic          deq;
  entry_t        head_e;

  assign count = count_q;

  // Grant lowest-index requesters first, against the space known at the
  // start of the cycle; a dequeue in the same cycle does not free a slot.
  always_comb begin
    free      = 32'(DEPTH) - 32'(count_q);
    nvld      = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !flush && !reset && (nvld < free);
      if (req_valid[i]) nvld = nvld + 32'd1;
    end
  end

  // Offer the head entry; payload reads as zero whenever nothing is offered.
  always_comb begin
    head_e        = mem_q[head_q];
    upd_valid     = (count_q != '0) && !flush && !reset;
    upd_pc        = upd_valid ? head_e.pc  : '0;
    upd_direction = upd_valid ? head_e.dir : 1'b0;
    upd_target    = upd_valid ? head_e.tgt : '0;
    deq           = upd_valid && upd_ready;
  end

  // Next state: pack accepted requests at tail in index order, pop head,
  // and clear everything on flush/reset (reset also wipes the storage).
  always_comb begin
    mem_d = mem_q;
    nacc  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        mem_d[tail_q + AW'(nacc)] = '{pc: req_pc[i], dir: req_direction[i], tgt: req_target[i]};
        nacc = nacc + 32'd1;
      end
    end
    head_d  = head_q + AW'(deq);
    tail_d  = tail_q + AW'(nacc);
    count_d = count_q + CW'(nacc) - CW'(deq);
    if (reset || flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem_d[k] = '0;
    end
  end

  // State registers; synchronous reset is folded into the _d logic above.
  always_ff @(posedge clock) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
    mem_q   <= mem_d;
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: table of directed cycles with fixed
// expectations, plus a queue-based scoreboard checking every cycle.
module tb_bp_update_scheduler;

  localparam int NREQ  = 3;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      flush;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][XLEN-1:0] req_pc;
  logic [NREQ-1:0]           req_direction;
  logic [NREQ-1:0][XLEN-1:0] req_target;
  logic [NREQ-1:0]           req_ready;
  logic                      upd_valid;
  logic [XLEN-1:0]           upd_pc;
  logic                      upd_direction;
  logic [XLEN-1:0]           upd_target;
  logic                      upd_ready;
  logic [3:0]                count;

  bp_update_scheduler #(.NREQ(NREQ), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_pc(req_pc), .req_direction(req_direction),
    .req_target(req_target), .req_ready(req_ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_direction(upd_direction),
    .upd_target(upd_target), .upd_ready(upd_ready), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic        dir;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [2:0]  v;
    logic [31:0] base;
    logic        ur;
    logic [2:0]  e_rdy;
    logic [3:0]  e_cnt;
    logic        chk_cnt;
    logic        e_uv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t  tbl [24];
  ent_t  mq [$];
  int    total = 0;
  int    bad = 0;
  int    npop = 0;
  bit    mvalid = 0;
  int    nacc_last;

  localparam logic [31:0] SALT = 32'hA5A5_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs against the scoreboard,
  // then advance the scoreboard as the next rising edge will.
  task automatic step(input logic r, input logic f, input logic [2:0] v,
                      input logic [31:0] base, input logic [31:0] salt, input logic ur);
    logic [2:0] er;
    int         pre;
    int         free;
    logic       euv;
    ent_t       exp_e;
    @(negedge clock);
    reset = r; flush = f; req_valid = v; upd_ready = ur;
    for (int i = 0; i < NREQ; i++) begin
      req_pc[i]        = base + 32'(i) * 32'h80;
      req_target[i]    = req_pc[i] ^ salt;
      req_direction[i] = (i % 2) == 1;
    end
    #1;
    free = DEPTH - mq.size();
    pre  = 0;
    for (int i = 0; i < NREQ; i++) begin
      er[i] = !r && !f && (pre < free);
      if (v[i]) pre++;
    end
    euv   = (mq.size() != 0) && !r && !f;
    exp_e = euv ? mq[0] : '0;
    if (mvalid) chk("sb_count", 64'(count), 64'(mq.size()));
    chk("sb_ready", 64'(req_ready), 64'(er));
    chk("sb_upd_valid", 64'(upd_valid), 64'(euv));
    chk("sb_payload", 64'({upd_pc, upd_direction, upd_target} >> 1), 64'(exp_e >> 1));
    chk("sb_tgt", 64'({upd_direction, upd_target}), 64'({exp_e.dir, exp_e.tgt}));
    nacc_last = 0;
    if (r || f) mq.delete();
    else begin
      if (euv && ur) begin void'(mq.pop_front()); npop++; end
      for (int i = 0; i < NREQ; i++)
        if (v[i] && er[i]) begin
          mq.push_back('{pc: req_pc[i], dir: req_direction[i], tgt: req_target[i]});
          nacc_last++;
        end
    end
    if (r) mvalid = 1;
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic [2:0] v,
                              input logic [31:0] base, input logic ur, input logic [2:0] er,
                              input logic [3:0] ec, input logic cc, input logic euv,
                              input logic [31:0] epc);
    vec_t t;
    t.rst = r; t.fl = f; t.v = v; t.base = base; t.ur = ur;
    t.e_rdy = er; t.e_cnt = ec; t.chk_cnt = cc; t.e_uv = euv; t.e_pc = epc;
    return t;
  endfunction

  initial begin
    int sent;
    int cyc;
    int ri;
    reset = 1'b1; flush = 1'b0; req_valid = '0; upd_ready = 1'b0;
    req_pc = '0; req_target = '0; req_direction = '0;

    //            rst   fl    valid   base         ur    e_rdy   cnt   chk   uv    pc
    tbl[0]  = mk(1'b1, 1'b0, 3'b000, 32'h0,    1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 1'b0, 3'b000, 32'h0,    1'b0, 3'b000, 4'd0, 1'b1, 1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b0, 3'b111, 4'd0, 1'b1, 1'b0, 32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 3'b101, 32'h100,  1'b0, 3'b111, 4'd0, 1'b1, 1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b1, 3'b111, 4'd2, 1'b1, 1'b1, 32'h100);
    tbl[5]  = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b0, 3'b111, 4'd1, 1'b1, 1'b1, 32'h200);
    tbl[6]  = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b1, 3'b111, 4'd1, 1'b1, 1'b1, 32'h200);
    tbl[7]  = mk(1'b0, 1'b0, 3'b111, 32'h1000, 1'b0, 3'b111, 4'd0, 1'b1, 1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 1'b0, 3'b111, 32'h2000, 1'b0, 3'b111, 4'd3, 1'b1, 1'b1, 32'h1000);
    tbl[9]  = mk(1'b0, 1'b0, 3'b001, 32'h3000, 1'b0, 3'b111, 4'd6, 1'b1, 1'b1, 32'h1000);
    tbl[10] = mk(1'b0, 1'b0, 3'b111, 32'h4000, 1'b0, 3'b001, 4'd7, 1'b1, 1'b1, 32'h1000);
    tbl[11] = mk(1'b0, 1'b0, 3'b111, 32'h5000, 1'b1, 3'b000, 4'd8, 1'b1, 1'b1, 32'h1000);
    tbl[12] = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b0, 3'b111, 4'd7, 1'b1, 1'b1, 32'h1080);
    tbl[13] = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b1, 3'b111, 4'd7, 1'b1, 1'b1, 32'h1080);
    tbl[14] = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b1, 3'b111, 4'd6, 1'b1, 1'b1, 32'h1100);
    tbl[15] = mk(1'b0, 1'b1, 3'b011, 32'h9000, 1'b1, 3'b000, 4'd5, 1'b1, 1'b0, 32'h0);
    tbl[16] = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b0, 3'b111, 4'd0, 1'b1, 1'b0, 32'h0);
    tbl[17] = mk(1'b0, 1'b0, 3'b111, 32'h6000, 1'b0, 3'b111, 4'd0, 1'b1, 1'b0, 32'h0);
    tbl[18] = mk(1'b0, 1'b0, 3'b001, 32'h7000, 1'b0, 3'b111, 4'd3, 1'b1, 1'b1, 32'h6000);
    tbl[19] = mk(1'b1, 1'b0, 3'b111, 32'hA000, 1'b1, 3'b000, 4'd4, 1'b1, 1'b0, 32'h0);
    tbl[20] = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b0, 3'b111, 4'd0, 1'b1, 1'b0, 32'h0);
    tbl[21] = mk(1'b0, 1'b0, 3'b010, 32'h8000, 1'b0, 3'b111, 4'd0, 1'b1, 1'b0, 32'h0);
    tbl[22] = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b1, 3'b111, 4'd1, 1'b1, 1'b1, 32'h8080);
    tbl[23] = mk(1'b0, 1'b0, 3'b000, 32'h0,    1'b0, 3'b111, 4'd0, 1'b1, 1'b0, 32'h0);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].fl, tbl[k].v, tbl[k].base, SALT, tbl[k].ur);
      chk($sformatf("v%0d_ready", k), 64'(req_ready), 64'(tbl[k].e_rdy));
      chk($sformatf("v%0d_uv", k), 64'(upd_valid), 64'(tbl[k].e_uv));
      chk($sformatf("v%0d_pc", k), 64'(upd_pc), 64'(tbl[k].e_pc));
      if (tbl[k].chk_cnt) chk($sformatf("v%0d_count", k), 64'(count), 64'(tbl[k].e_cnt));
    end

    // 20 single requests, duplicate PCs in pairs, upd_ready toggling; order
    // across pointer wrap is checked by the scoreboard on every pop.
    npop = 0;
    sent = 0;
    cyc  = 0;
    while (sent < 20 && cyc < 300) begin
      ri = sent % 3;
      step(1'b0, 1'b0, 3'(1 << ri), 32'h500 + 32'((sent >> 1) * 4) - 32'(ri) * 32'h80,
           32'(sent), cyc[0]);
      chk("wrap_cnt_le8", 64'(count <= 4'd8), 64'd1);
      sent += nacc_last;
      cyc++;
    end
    chk("wrap_all_sent", 64'(sent), 64'd20);
    while (mq.size() != 0 && cyc < 400) begin
      step(1'b0, 1'b0, 3'b000, 32'h0, SALT, 1'b1);
      cyc++;
    end
    step(1'b0, 1'b0, 3'b000, 32'h0, SALT, 1'b0);
    chk("wrap_pops", 64'(npop), 64'd20);
    chk("wrap_empty_count", 64'(count), 64'd0);
    chk("wrap_empty_uv", 64'(upd_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
